fir_decimator_out: RTL and testbench

Output stage for the FIR Gaussian lowpass path. It takes the filter's free-running full-precision sum and removes the coefficient gain by right shift with rounding and saturation. It then keeps one of every `decim` valid samples and buffers the result in a 2-entry FIFO behind a valid/ready handshake toward the downstream HRTF consumer. It is the reader end of the filter's output word.

---
 rtl/fir_decimator_out_pkg.sv | 13 +
 rtl/fir_decimator_out_if.sv | 19 +
 rtl/fir_decimator_out_fifo.sv | 66 ++++++
 rtl/fir_decimator_out.sv | 72 +++++++
 tb/tb_fir_decimator_out.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fir_decimator_out_pkg.sv
// Shared defaults and FIFO occupancy encoding for the FIR decimator output stage.
package fir_decimator_out_pkg;
  localparam int WORD_IN_DEF  = 18;
  localparam int WORD_OUT_DEF = 8;
  localparam int SHIFT_DEF    = 8;
  localparam int DECIM_DEF    = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_st_e;
endpackage

// File: rtl/fir_decimator_out_if.sv
// Filter-side sample input plus consumer-side valid/ready output of the decimator.
interface fir_decimator_out_if #(
  parameter int WI = fir_decimator_out_pkg::WORD_IN_DEF,
  parameter int WO = fir_decimator_out_pkg::WORD_OUT_DEF
);
  logic          clear;
  logic [WI-1:0] Data_in;
  logic          in_valid;
  logic [WO-1:0] Data_out;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic [15:0]   count;

  modport master (output clear, Data_in, in_valid, out_ready,
                  input  Data_out, out_valid, overflow, count);
  modport slave  (input  clear, Data_in, in_valid, out_ready,
                  output Data_out, out_valid, overflow, count);
endinterface

// File: rtl/fir_decimator_out_fifo.sv
// fir_out_fifo: 2-entry FIFO, head/tail registers steered by an occupancy FSM.
module fir_out_fifo
  import fir_decimator_out_pkg::*;
#(
  parameter int W = WORD_OUT_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  fifo_st_e     r_st, w_nxt;
  logic [W-1:0] r_head, r_tail;

  always_ff @(posedge clock or negedge reset)
    if (!reset) r_st <= EMPTY;
    else        r_st <= w_nxt;

  always_comb begin
    w_nxt = r_st;
    if (clear) w_nxt = EMPTY;
    else begin
      case (r_st)
        EMPTY:   if (i_push) w_nxt = ONE;
        ONE:     if (i_push && !i_pop) w_nxt = FULL;
                 else if (!i_push && i_pop) w_nxt = EMPTY;
        FULL:    if (i_pop && !i_push) w_nxt = ONE;
        default: w_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    o_empty = (r_st == EMPTY);
    o_full  = (r_st == FULL);
    o_head  = r_head;
  end

  // A push while FULL without a pop leaves storage untouched (sample dropped)
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (clear) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_st)
        EMPTY: if (i_push) r_head <= i_din;
        ONE: begin
          if (i_push && i_pop) r_head <= i_din;
          else if (i_push)     r_tail <= i_din;
        end
        FULL: if (i_pop) begin
          r_head <= r_tail;
          if (i_push) r_tail <= i_din;
        end
        default: ;
      endcase
    end
endmodule

// File: rtl/fir_decimator_out.sv
// FIR output stage: scale (round/saturate), decimate, buffer in a 2-entry FIFO.
// Define FIR_DEC_ROUND_EN for round-half-up scaling; otherwise plain truncation.
module fir_decimator_out
  import fir_decimator_out_pkg::*;
#(
  parameter int word_size_in  = WORD_IN_DEF,
  parameter int word_size_out = WORD_OUT_DEF,
  parameter int shift         = SHIFT_DEF,
  parameter int decim         = DECIM_DEF
) (
  input  logic                clock,
  input  logic                reset,
  fir_decimator_out_if.slave  bus
);
  localparam int PW = (decim > 1) ? $clog2(decim) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(decim - 1);
  localparam logic [word_size_in:0] MAXV =
    {{(word_size_in + 1 - word_size_out){1'b0}}, {word_size_out{1'b1}}};

  logic [PW-1:0]            r_phase;
  logic                     r_ovf;
  logic [15:0]              r_count;
  logic [word_size_in:0]    w_sum, w_r;
  logic [word_size_out-1:0] w_scaled, w_head;
  logic                     w_keep, w_pop, w_full, w_empty, w_accept;

  // One extra bit of headroom so the rounding add never wraps
`ifdef FIR_DEC_ROUND_EN
  localparam logic [word_size_in:0] RND = {{word_size_in{1'b0}}, 1'b1} << (shift - 1);
  assign w_sum = {1'b0, bus.Data_in} + RND;
`else
  assign w_sum = {1'b0, bus.Data_in};
`endif
  assign w_r      = w_sum >> shift;
  assign w_scaled = (w_r > MAXV) ? '1 : w_r[word_size_out-1:0];

  assign w_keep   = bus.in_valid && !bus.clear && (r_phase == '0);
  assign w_pop    = bus.out_ready && !w_empty && !bus.clear;
  assign w_accept = w_keep && (!w_full || w_pop);

  fir_out_fifo #(.W(word_size_out)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear   (bus.clear),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_din   (w_scaled),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_phase <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (bus.clear) begin
      r_phase <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      if (bus.in_valid) r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      if (w_keep && !w_accept) r_ovf <= 1'b1;
      if (w_accept) r_count <= r_count + 16'd1;
    end

  assign bus.Data_out  = w_head;
  assign bus.out_valid = !w_empty;
  assign bus.overflow  = r_ovf;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_fir_decimator_out.sv
// Directed bench: decim=1 and decim=2 instances, vector table plus corner sequences.
module tb_fir_decimator_out;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fir_decimator_out_if #(.WI(18), .WO(8)) b1 ();
  fir_decimator_out_if #(.WI(18), .WO(8)) b2 ();

  fir_decimator_out #(.word_size_in(18), .word_size_out(8), .shift(8), .decim(1))
    dut1 (.clock(clock), .reset(reset), .bus(b1.slave));
  fir_decimator_out #(.word_size_in(18), .word_size_out(8), .shift(8), .decim(2))
    dut2 (.clock(clock), .reset(reset), .bus(b2.slave));

`ifdef FIR_DEC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct { int din; int exp; } vec_t;
  vec_t vt[8];
  int   n_cmp = 0;
  int   n_err = 0;
  int   q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push1(input int d);
    b1.Data_in = 18'(d); b1.in_valid = 1'b1;
    @(negedge clock);
    b1.in_valid = 1'b0;
  endtask

  task automatic clr1();
    b1.clear = 1'b1;
    @(negedge clock);
    b1.clear = 1'b0;
  endtask

  initial begin
    vt[0] = '{1408,   RND ? 6 : 5};
    vt[1] = '{262143, 255};
    vt[2] = '{0,      0};
    vt[3] = '{127,    0};
    vt[4] = '{128,    RND ? 1 : 0};
    vt[5] = '{65407,  255};
    vt[6] = '{65408,  255};
    vt[7] = '{300,    1};

    b1.clear = 0; b1.in_valid = 0; b1.Data_in = '0; b1.out_ready = 0;
    b2.clear = 0; b2.in_valid = 0; b2.Data_in = '0; b2.out_ready = 0;
    repeat (2) @(negedge clock);
    chk("rst_data", b1.Data_out, 0);
    chk("rst_valid", b1.out_valid, 0);
    chk("rst_ovf", b1.overflow, 0);
    chk("rst_count", b1.count, 0);
    chk("rst_valid2", b2.out_valid, 0);
    reset = 1'b1;
    @(negedge clock);

    // Scaling table, decim=1, consumer always ready
    b1.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push1(vt[i].din);
      chk($sformatf("vec%0d_valid", i), b1.out_valid, 1);
      chk($sformatf("vec%0d_data", i), b1.Data_out, vt[i].exp);
      @(negedge clock);
      chk($sformatf("vec%0d_drain", i), b1.out_valid, 0);
    end
    chk("vec_count", b1.count, 8);

    // Back-to-back samples stream out one per clock
    for (int i = 1; i <= 3; i++) begin
      b1.Data_in = 18'(i * 256); b1.in_valid = 1'b1;
      @(negedge clock);
      chk($sformatf("thru%0d", i), b1.Data_out, i);
      chk($sformatf("thru%0d_v", i), b1.out_valid, 1);
    end
    b1.in_valid = 1'b0;
    @(negedge clock);

    // Decimation by 2
    b2.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b2.in_valid = (i < 4); b2.Data_in = 18'((i + 1) * 256);
      @(negedge clock);
      if (b2.out_valid) q.push_back(int'(b2.Data_out));
    end
    b2.in_valid = 1'b0;
    chk("dec_n", q.size(), 2);
    if (q.size() == 2) begin
      chk("dec_q0", q[0], 1);
      chk("dec_q1", q[1], 3);
    end
    chk("dec_count", b2.count, 2);

    // Backpressure and overflow
    clr1();
    b1.out_ready = 1'b0;
    push1(256);
    push1(512);
    chk("bp_ovf_full", b1.overflow, 0);
    push1(768);
    chk("bp_ovf", b1.overflow, 1);
    chk("bp_valid", b1.out_valid, 1);
    chk("bp_head", b1.Data_out, 1);
    @(negedge clock);
    chk("bp_stable", b1.Data_out, 1);
    b1.out_ready = 1'b1;
    @(negedge clock);
    chk("bp_second", b1.Data_out, 2);
    @(negedge clock);
    chk("bp_drained", b1.out_valid, 0);
    chk("bp_count", b1.count, 2);
    chk("bp_ovf_sticky", b1.overflow, 1);

    // Full FIFO with push and pop on the same edge
    clr1();
    b1.out_ready = 1'b0;
    push1(256);
    push1(512);
    b1.out_ready = 1'b1;
    push1(1024);
    chk("pp_ovf", b1.overflow, 0);
    chk("pp_d0", b1.Data_out, 2);
    @(negedge clock);
    chk("pp_d1", b1.Data_out, 4);
    chk("pp_v1", b1.out_valid, 1);
    @(negedge clock);
    chk("pp_empty", b1.out_valid, 0);
    chk("pp_count", b1.count, 3);

    // Clear beats a concurrent sample and pop
    b1.out_ready = 1'b0;
    push1(256); push1(512); push1(768);
    b1.clear = 1'b1; b1.in_valid = 1'b1; b1.Data_in = 18'd1024; b1.out_ready = 1'b1;
    @(negedge clock);
    b1.clear = 1'b0; b1.in_valid = 1'b0;
    chk("clr_valid", b1.out_valid, 0);
    chk("clr_ovf", b1.overflow, 0);
    chk("clr_count", b1.count, 0);
    @(negedge clock);
    chk("clr_discard", b1.out_valid, 0);

    // Clear returns the decimation phase to 0
    b2.Data_in = 18'd256; b2.in_valid = 1'b1;
    @(negedge clock);
    b2.in_valid = 1'b0; b2.clear = 1'b1;
    @(negedge clock);
    b2.clear = 1'b0; b2.Data_in = 18'd1280; b2.in_valid = 1'b1;
    @(negedge clock);
    b2.in_valid = 1'b0;
    chk("ph_valid", b2.out_valid, 1);
    chk("ph_data", b2.Data_out, 5);

    // Asynchronous reset mid-stream
    b1.out_ready = 1'b0;
    push1(256); push1(512); push1(768);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", b1.out_valid, 0);
    chk("ar_data", b1.Data_out, 0);
    chk("ar_ovf", b1.overflow, 0);
    chk("ar_count", b1.count, 0);
    chk("ar_count2", b2.count, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("ar_after", b1.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
